// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-256 key-schedule engine.
// Build option: define AES_KS_INVMIX_EN to return InvMixColumns-transformed
// round keys 1..13 on the read port (equivalent inverse cipher keys).
package aes_pkg;

    localparam int unsigned NR        = 14;
    localparam int unsigned NUM_RK    = NR + 1;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned LAST_STEP = NR - 2;
    localparam int unsigned RCON_N    = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_e;

    // One 128-bit round key, w0 is the most significant word.
    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
    } round_key_t;

    localparam logic [7:0] RCON [RCON_N] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    // Cyclic left rotation by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; byte 0 is the most significant byte.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // InvMixColumns across all four columns of a round key.
    function automatic round_key_t inv_mix_columns(input round_key_t rk);
        round_key_t r;
        r.w0 = inv_mix_column(rk.w0);
        r.w1 = inv_mix_column(rk.w1);
        r.w2 = inv_mix_column(rk.w2);
        r.w3 = inv_mix_column(rk.w3);
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte in, one byte out, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out_c
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_out_c = SBOX[byte_in];

endmodule

// File: rtl/aes256_key_sched.sv
// Iterative AES-256 key schedule: one round key per cycle into a 15-entry
// register file, read back through a registered index port.
// Build option: AES_KS_INVMIX_EN applies InvMixColumns to keys 1..13 on read.
module aes256_key_sched
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [255:0]     key,
    output logic             keys_valid,
    input  logic [IDX_W-1:0] rk_rd_idx,
    output logic [127:0]     rk_rd_data
);

    ks_state_e         state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              key_ready_q, key_ready_d;
    logic              keys_valid_q, keys_valid_d;
    round_key_t        rk_q [NUM_RK];
    round_key_t        rk_d [NUM_RK];
    logic [127:0]      rk_rd_data_q, rk_rd_data_d;

    logic              accept_c;
    logic [IDX_W-1:0]  base_idx_c, prev_idx_c, wr_idx_c;
    round_key_t        base_rk_c, prev_rk_c, new_rk_c, rd_raw_c;
    logic [31:0]       sub_in_c, sub_out_c, t_mix_c;

    // Select the two source round keys and the word to be substituted.
    always_comb begin
        base_idx_c = IDX_W'(step_q);
        prev_idx_c = base_idx_c + IDX_W'(1);
        wr_idx_c   = base_idx_c + IDX_W'(2);
        base_rk_c  = rk_q[base_idx_c];
        prev_rk_c  = rk_q[prev_idx_c];
        sub_in_c   = step_q[0] ? prev_rk_c.w3 : rot_word(prev_rk_c.w3);
    end

    // SubWord: four byte-wide S-box lookups.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_in    (sub_in_c[8*gi +: 8]),
            .byte_out_c (sub_out_c[8*gi +: 8])
        );
    end

    // Round-constant injection on even steps, then the word XOR chain.
    always_comb begin
        t_mix_c = sub_out_c;
        if (!step_q[0]) begin
            t_mix_c = sub_out_c ^ {RCON[step_q[3:1]], 24'h0};
        end
        new_rk_c.w0 = base_rk_c.w0 ^ t_mix_c;
        new_rk_c.w1 = base_rk_c.w1 ^ new_rk_c.w0;
        new_rk_c.w2 = base_rk_c.w2 ^ new_rk_c.w1;
        new_rk_c.w3 = base_rk_c.w3 ^ new_rk_c.w2;
    end

    // FSM next state, step counter, handshake flags and register-file writes.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        key_ready_d  = key_ready_q;
        keys_valid_d = keys_valid_q;
        rk_d         = rk_q;
        accept_c     = key_valid && key_ready_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_c) begin
                    state_d      = ST_EXPAND;
                    step_d       = '0;
                    key_ready_d  = 1'b0;
                    keys_valid_d = 1'b0;
                    rk_d[0]      = key[255:128];
                    rk_d[1]      = key[127:0];
                end
            end
            ST_EXPAND: begin
                rk_d[wr_idx_c] = new_rk_c;
                if (step_q == STEP_W'(LAST_STEP)) begin
                    state_d      = ST_DONE;
                    key_ready_d  = 1'b1;
                    keys_valid_d = 1'b1;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                key_ready_d = 1'b1;
            end
        endcase
    end

    // Read mux; index 15 has no backing entry and reads as zero.
    always_comb begin
        rd_raw_c = '0;
        if (rk_rd_idx <= IDX_W'(NR)) begin
            rd_raw_c = rk_q[rk_rd_idx];
        end
`ifdef AES_KS_INVMIX_EN
        if ((rk_rd_idx != '0) && (rk_rd_idx < IDX_W'(NR))) begin
            rk_rd_data_d = inv_mix_columns(rd_raw_c);
        end else begin
            rk_rd_data_d = rd_raw_c;
        end
`else
        rk_rd_data_d = rd_raw_c;
`endif
    end

    // Control and read-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            key_ready_q  <= 1'b1;
            keys_valid_q <= 1'b0;
            rk_rd_data_q <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            key_ready_q  <= key_ready_d;
            keys_valid_q <= keys_valid_d;
            rk_rd_data_q <= rk_rd_data_d;
        end
    end

    // Register file has no reset; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rk_q <= rk_d;
        end
    end

    assign key_ready  = key_ready_q;
    assign keys_valid = keys_valid_q;
    assign rk_rd_data = rk_rd_data_q;

endmodule

// File: doc/aes256_key_sched.md
Name: aes256_key_sched

Overview:
- Iterative AES-256 key-schedule engine. It sits directly upstream of the AES-256 decipher datapath.
- Accepts a 256-bit cipher key and expands it over 13 clock cycles into the 15 round keys. The round keys are stored in an internal register file.
- The decipher reads round keys by index, 14 down to 0, through a registered read port. This replaces the 7-stage combinational expansion chain with one expansion step per cycle.

Parameters:
- NR, 14, number of AES-256 rounds. Fixed; 15 round keys are stored.
- IDX_W, 4, width of the round-key read index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  a new cipher key is presented on key.
- key_ready  out  1  engine can accept a key (IDLE or DONE).
- key  in  256  cipher key; key[255:128] is round key 0.
- keys_valid  out  1  all 15 round keys are stored and stable.
- rk_rd_idx  in  4  round-key index 0..14, in encryption round numbering.
- rk_rd_data  out  128  registered round key for the index presented the previous cycle.

Behaviour:
- Reset values: key_ready=1, keys_valid=0, rk_rd_data=0. The FSM goes to IDLE and the step counter to 0. Register file contents are don't-care.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE -> EXPAND on key_valid && key_ready.
  - EXPAND -> DONE after step 12.
  - DONE -> EXPAND on key_valid && key_ready.
- Accept cycle (handshake edge):
  - rk[0] <= key[255:128]; rk[1] <= key[127:0]; step <= 0.
  - key_ready and keys_valid drop to 0 on the next cycle.
- EXPAND, step s = 0..12: one round key per cycle, rk[s+2] <= {w0,w1,w2,w3}.
  - t = last word of rk[s+1].
  - s even: t' = SubWord(RotWord(t)) ^ {rcon[s/2],24'h0}, with rcon = 01,02,04,08,10,20,40.
  - s odd: t' = SubWord(t).
  - w0 = rk[s].w0 ^ t', and w(k) = rk[s].w(k) ^ w(k-1) for k = 1..3. The chain is combinational within the cycle.
- Latency: the accept edge, then 13 EXPAND cycles. keys_valid rises on the cycle after step 12 is written, i.e. the 14th edge after acceptance.
- key_ready is asserted only in IDLE and DONE. A key_valid raised during EXPAND is ignored and is not queued.
- Read port:
  - rk_rd_data <= rk[rk_rd_idx] every cycle, 1-cycle latency, regardless of state.
  - Data is meaningful only while keys_valid=1.
  - Index 15 returns 128'h0.
- Re-key in DONE: keys_valid drops the cycle after acceptance. Reads during re-expansion return partially updated contents.
- rst mid-EXPAND: abort to IDLE, keys_valid=0, no further register-file writes.
- Simultaneous rst and key_valid: rst wins.

Optional Feature:
- Macro AES_KS_INVMIX_EN.
- Defined: on the read path, InvMixColumns is applied to round keys 1..13 before the read register, giving equivalent-inverse-cipher keys. Indices 0 and 14 are unmodified. Latency is still 1 cycle.
- Undefined: raw FIPS-197 round keys are returned for all indices.

Decomposition:
- Package aes_pkg:
  - FSM state enum.
  - rcon constant array (7 x 8 bits).
  - NR constant.
  - Functions rot_word, xtime and inv_mix_column.
- One sub-module, aes_sbox: a 256-entry forward S-box LUT, byte in to byte out. It is instantiated 4 times for SubWord.

Test Plan:
- Reset then idle -> key_ready=1, keys_valid=0, rk_rd_data=0.
- FIPS-197 C.3 key 000102..1f, macro undefined:
  - keys_valid rises 14 edges after the handshake.
  - idx 1 -> 101112131415161718191a1b1c1d1e1f.
  - idx 2 -> a573c29fa176c498a97fce93a572c09c.
  - idx 14 -> 24fc79ccbf0979e9371ac23c6d68de36.
  - idx 15 -> 0.
- key_valid held high throughout EXPAND with a second key -> ignored. The first key's schedule completes; the second key is accepted only once DONE is reached.
- rst asserted at step 6 -> IDLE next cycle, keys_valid stays 0. A fresh key then expands correctly.
- Re-key from DONE with all-zero key -> keys_valid low for 13 cycles. idx 14 -> value matching the software reference model.
- AES_KS_INVMIX_EN defined, key 000102..1f -> idx 0 and 14 match raw values; idx 1..13 equal InvMixColumns of the raw key per the reference model.
